// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder controller around a one-bit full-add slice
//
// Purpose: captures two operands and a carry-in on start, adds them LSB-first
// one bit per cycle through a single full-add slice with a registered carry,
// then presents the parallel sum and carry-out with a one-cycle done pulse.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - begin an addition (ignored while busy)
//   a, b   - WIDTH-bit operands captured on accepted start
//   c_in   - carry-in captured on accepted start
//   busy   - high while bits are being shifted through the slice
//   done   - one-cycle pulse when sum/c_out are freshly valid
//   sum    - registered result, held until the next result
//   c_out  - registered carry-out, held with sum
//   ovf    - signed overflow flag (only when SERIAL_ADDER_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // One-bit full-add slice fed from the operand LSBs and the carry register.
  logic             slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] p_shifted;

  assign slice_s  = a_q[0] ^ b_q[0] ^ cy_q;
  assign slice_co = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

  // Partial sum fills from the top so that after WIDTH shifts bit 0 of the
  // result sits in P[0].
  assign p_shifted = (p_q >> 1) | (WIDTH'(slice_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        // A start seen in DONE is accepted immediately for back-to-back use.
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          cy_d    = c_in;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        p_d   = p_shifted;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = slice_co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = p_shifted;
          c_out_d = slice_co;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB differs from carry out of the MSB.
          ovf_d   = cy_q ^ slice_co;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic cur_ovf();
`ifdef SERIAL_ADDER_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one start pulse and wait for the result; reports latency in edges.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         output logic [W-1:0] rs, output logic rc, output logic ro,
                         output int lat);
    int n;
    @(negedge clk);
    a = ta; b = tb; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
      lat = -1;
    end else begin
      lat = n;
    end
    rs = sum; rc = c_out; ro = cur_ovf();
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    int           lat, dcount, k;
    logic [W-1:0] ra, rb;
    logic         rcin;
    logic [W:0]   tot;
    int           st;
    logic [W-1:0] got;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum", {24'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, c_out}, 32'd0);
    chk("reset_ovf", {31'd0, cur_ovf()}, 32'd0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_add(tbl[i].va, tbl[i].vb, tbl[i].vc, rs, rc, ro, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd8);
      chk($sformatf("tbl%0d_sum", i), {24'd0, rs}, {24'd0, tbl[i].es});
      chk($sformatf("tbl%0d_cout", i), {31'd0, rc}, {31'd0, tbl[i].eco});
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ro}, {31'd0, tbl[i].eov});
`endif
    end

    // Result holds through idle
    repeat (3) @(negedge clk);
    chk("hold_sum_idle", {24'd0, sum}, {24'd0, tbl[6].es});
    chk("hold_cout_idle", {31'd0, c_out}, {31'd0, tbl[6].eco});

    // Randomized against an arithmetic model
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
      tot = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
      st  = int'($signed(ra)) + int'($signed(rb)) + int'(rcin);
      run_add(ra, rb, rcin, rs, rc, ro, lat);
      chk($sformatf("rnd%0d_latency", i), lat, 32'd8);
      chk($sformatf("rnd%0d_sum", i), {24'd0, rs}, {24'd0, tot[W-1:0]});
      chk($sformatf("rnd%0d_cout", i), {31'd0, rc}, {31'd0, tot[W]});
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), {31'd0, ro}, {31'd0, (st > 127 || st < -128)});
`endif
    end

    // Start during SHIFT is ignored
    @(negedge clk);
    a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0; lat = -1; got = '0;
    for (k = 1; k <= 14; k++) begin
      if (k == 3) begin start = 1'b1; a = 8'hAA; end
      if (k == 4) begin start = 1'b0; a = 8'h0F; end
      @(negedge clk);
      if (done) begin
        dcount++;
        if (lat < 0) begin lat = k; got = sum; end
      end
    end
    chk("ignore_done_count", dcount, 32'd1);
    chk("ignore_latency", lat, 32'd8);
    chk("ignore_sum", {24'd0, got}, 32'h10);

    // Start held high: back-to-back additions
    @(negedge clk);
    a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
    dcount = 0;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      chk($sformatf("held_done_e%0d", k), {31'd0, done}, {31'd0, (k % 9 == 8)});
      chk($sformatf("held_busy_e%0d", k), {31'd0, busy}, {31'd0, (k % 9 != 8)});
      if (done) begin
        dcount++;
        chk($sformatf("held_sum_e%0d", k), {24'd0, sum}, 32'h03);
      end
    end
    chk("held_done_count", dcount, 32'd3);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    chk("held_drain_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // Reset mid-operation aborts
    a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, c_out}, 32'd0);
    dcount = 0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);
    run_add(8'h0F, 8'h01, 1'b0, rs, rc, ro, lat);
    chk("fresh_latency", lat, 32'd8);
    chk("fresh_sum", {24'd0, rs}, 32'h10);
    chk("fresh_cout", {31'd0, rc}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
